// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor D = A - B, LSB first, one bit per clock.
// Operands load on an accepted start; D/Bout update only on the completion edge.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bor_q, bor_d, bout_q, bout_d, busy_q, busy_d, done_q, done_d;
    logic             diff, bor_nx;

    assign diff   = a_q[0] ^ b_q[0] ^ bor_q;
    assign bor_nx = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bor_q);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        bor_d   = bor_q;
        d_d     = d_q;
        bout_d  = bout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    res_d   = '0;
                    cnt_d   = '0;
                    bor_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = {diff, res_q[WIDTH-1:1]};
                bor_d = bor_nx;
                cnt_d = cnt_q + CW'(1);
                // Last bit: publish the completed word straight from the shift path.
                if (cnt_q == LAST) begin
                    d_d     = {diff, res_q[WIDTH-1:1]};
                    bout_d  = bor_nx;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            bor_q   <= 1'b0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            bor_q   <= bor_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign D    = d_q;
    assign Bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: WIDTH=8 vector table and corner sequences,
// plus a full WIDTH=4 operand sweep on a second instance.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] A, B;
    logic       busy, done, Bout;
    logic [7:0] D;

    logic       start4;
    logic [3:0] A4, B4;
    logic       busy4, done4, Bout4;
    logic [3:0] D4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
        .busy(busy), .done(done), .D(D), .Bout(Bout)
    );

    serial_subtractor #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .A(A4), .B(B4),
        .busy(busy4), .done(done4), .D(D4), .Bout(Bout4)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       bout;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Starts one WIDTH=8 operation from IDLE/DONE; returns at #1 after the done edge.
    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       output int lat, output int busy_cnt);
        A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; busy_cnt = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, output int lat);
        A4 = a; B4 = b; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        lat = 0;
        while (!done4 && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat, bc, pulses, last_cyc, done_cyc;
        logic prev_done;
        logic [7:0] cap_d;
        logic       cap_b;
        logic [7:0] ea, eb;

        vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1};
        vecs[2] = '{8'h00, 8'hFF, 8'h01, 1'b1};
        vecs[3] = '{8'hFF, 8'h01, 8'hFE, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 8'h00, 1'b0};
        vecs[5] = '{8'hAA, 8'h55, 8'h55, 1'b0};
        vecs[6] = '{8'h80, 8'h7F, 8'h01, 1'b0};
        vecs[7] = '{8'h7F, 8'h80, 8'hFF, 1'b1};

        rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
        start4 = 1'b0; A4 = '0; B4 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_D", 32'(D), 32'd0);
        chk("reset_Bout", 32'(Bout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            op8(vecs[i].a, vecs[i].b, lat, bc);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd8);
            chk($sformatf("vec%0d_busy_cycles", i), 32'(bc), 32'd8);
            chk($sformatf("vec%0d_busy_at_done", i), 32'(busy), 32'd0);
            chk($sformatf("vec%0d_D", i), 32'(D), 32'(vecs[i].d));
            chk($sformatf("vec%0d_Bout", i), 32'(Bout), 32'(vecs[i].bout));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_done_cleared", i), 32'(done), 32'd0);
            chk($sformatf("vec%0d_D_held", i), 32'(D), 32'(vecs[i].d));
        end

        // Start during RUN ignored; operand changes after capture ignored.
        A = 8'h10; B = 8'h01; start = 1'b1;
        @(posedge clk); #1;
        pulses = 0; done_cyc = -1; cap_d = '0; cap_b = 1'b0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (cyc == 3) begin
                start = 1'b1; A = 8'h00; B = 8'h01;
            end else begin
                start = 1'b0; A = 8'($urandom); B = 8'($urandom);
            end
            @(posedge clk); #1;
            if (done) begin
                pulses++;
                done_cyc = cyc;
                cap_d = D;
                cap_b = Bout;
            end
        end
        start = 1'b0;
        chk("ignore_start_pulses", 32'(pulses), 32'd1);
        chk("ignore_start_done_cycle", 32'(done_cyc), 32'd8);
        chk("ignore_start_D", 32'(cap_d), 32'h0F);
        chk("ignore_start_Bout", 32'(cap_b), 32'd0);
        chk("ignore_start_idle", 32'(busy), 32'd0);

        // Start held high: back-to-back operations every WIDTH+1 cycles.
        A = 8'h20; B = 8'h10; start = 1'b1;
        pulses = 0; last_cyc = -1; prev_done = 1'b0;
        for (int cyc = 0; cyc <= 44; cyc++) begin
            @(posedge clk); #1;
            if (done) begin
                pulses++;
                chk("b2b_D", 32'(D), 32'h10);
                chk("b2b_Bout", 32'(Bout), 32'd0);
                chk("b2b_not_consecutive", 32'(prev_done), 32'd0);
                if (last_cyc >= 0) chk("b2b_spacing", 32'(cyc - last_cyc), 32'd9);
                else chk("b2b_first_done", 32'(cyc), 32'd8);
                last_cyc = cyc;
            end
            prev_done = done;
        end
        start = 1'b0;
        chk("b2b_pulse_count", 32'(pulses), 32'd5);
        @(posedge clk); #1;

        // Reset mid-RUN aborts with no done pulse; D (currently 0x10) must clear.
        A = 8'hAA; B = 8'h55; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_D", 32'(D), 32'd0);
        chk("midrst_Bout", 32'(Bout), 32'd0);
        pulses = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(posedge clk); #1;
            if (done || busy) pulses++;
        end
        chk("midrst_quiet", 32'(pulses), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        op8(8'h09, 8'h04, lat, bc);
        chk("post_rst_latency", 32'(lat), 32'd8);
        chk("post_rst_D", 32'(D), 32'h05);
        chk("post_rst_Bout", 32'(Bout), 32'd0);
        @(posedge clk); #1;

        // Full WIDTH=4 sweep.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                op4(4'(a), 4'(b), lat);
                ea = 8'((a - b) & 15);
                eb = (a < b) ? 8'd1 : 8'd0;
                chk($sformatf("w4_lat_%0d_%0d", a, b), 32'(lat), 32'd4);
                chk($sformatf("w4_D_%0d_%0d", a, b), 32'(D4), 32'(ea));
                chk($sformatf("w4_Bout_%0d_%0d", a, b), 32'(Bout4), 32'(eb));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1);
    end

endmodule
